// File: rtl/ysyx_23060184_rf_wb_arb_pkg.sv
// Shared core definitions for the register-file writeback arbiter: requester
// encoding, pending-counter width and the saturating counter step.
package ysyx_23060184_rf_wb_arb_pkg;

   typedef enum logic {
      REQ_EXU = 1'b0,
      REQ_LSU = 1'b1
   } req_e;

   localparam int CNT_W = 2;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Simultaneous reserve and retire cancel; a retire at zero stays at zero.
   function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c,
                                                 input logic inc,
                                                 input logic dec);
      logic [CNT_W-1:0] n;
      if (inc && !dec) begin
         n = c + CNT_W'(1);
      end else if (dec && !inc && (c != {CNT_W{1'b0}})) begin
         n = c - CNT_W'(1);
      end else begin
         n = c;
      end
      return n;
   endfunction

endpackage

// File: rtl/ysyx_23060184_rr_arb2.sv
// Two-input round-robin arbiter; grant vector bit 0 = EXU, bit 1 = LSU.
module ysyx_23060184_rr_arb2
   import ysyx_23060184_rf_wb_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   req_e       last_grant_r;
   logic [1:0] gnt_s;

   // Grant selection: sole requester wins, contention goes to the one not served last.
   always_comb begin
      gnt_s = 2'b00;
      if (rst) begin
         gnt_s = 2'b00;
      end else begin
         case (req)
            2'b01:   gnt_s = 2'b01;
            2'b10:   gnt_s = 2'b10;
            2'b11:   gnt_s = (last_grant_r == REQ_LSU) ? 2'b01 : 2'b10;
            default: gnt_s = 2'b00;
         endcase
      end
   end

   // Remember who was granted most recently.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_r <= REQ_LSU;
      end else if (gnt_s[0]) begin
         last_grant_r <= REQ_EXU;
      end else if (gnt_s[1]) begin
         last_grant_r <= REQ_LSU;
      end else begin
         last_grant_r <= last_grant_r;
      end
   end

   assign gnt = gnt_s;

endmodule

// File: rtl/ysyx_23060184_rf_wb_arb.sv
// Register-file writeback arbiter with per-register pending-write scoreboard.
// Optional same-cycle forwarding enabled by macro YSYX_23060184_RF_BYPASS_EN.
module ysyx_23060184_rf_wb_arb
   import ysyx_23060184_rf_wb_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  exu_valid,
   input  logic [ADDR_WIDTH-1:0] exu_waddr,
   input  logic [DATA_WIDTH-1:0] exu_wdata,
   output logic                  exu_ready,
   input  logic                  lsu_valid,
   input  logic [ADDR_WIDTH-1:0] lsu_waddr,
   input  logic [DATA_WIDTH-1:0] lsu_wdata,
   output logic                  lsu_ready,
   input  logic                  issue_valid,
   input  logic [ADDR_WIDTH-1:0] issue_rd,
   output logic                  issue_ready,
   input  logic [ADDR_WIDTH-1:0] rs1,
   input  logic [ADDR_WIDTH-1:0] rs2,
   output logic                  rs1_busy,
   output logic                  rs2_busy,
`ifdef YSYX_23060184_RF_BYPASS_EN
   output logic                  rs1_fwd,
   output logic [DATA_WIDTH-1:0] rs1_fwd_data,
   output logic                  rs2_fwd,
   output logic [DATA_WIDTH-1:0] rs2_fwd_data,
`endif
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata
);

   localparam int NREG = 2 ** ADDR_WIDTH;

   logic [1:0]            gnt_s;
   logic                  rf_wen_r;
   logic [ADDR_WIDTH-1:0] rf_waddr_r;
   logic [DATA_WIDTH-1:0] rf_wdata_r;
   logic [CNT_W-1:0]      cnt_r [NREG];
   logic                  issue_ready_s;
   logic                  inc_s;

   ysyx_23060184_rr_arb2 u_arb (
      .clk (clk),
      .rst (rst),
      .req ({lsu_valid, exu_valid}),
      .gnt (gnt_s)
   );

   assign exu_ready = gnt_s[int'(REQ_EXU)];
   assign lsu_ready = gnt_s[int'(REQ_LSU)];

   // Writeback stage: a grant to x0 is consumed but never raises rf_wen.
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_wen_r   <= 1'b0;
         rf_waddr_r <= {ADDR_WIDTH{1'b0}};
         rf_wdata_r <= {DATA_WIDTH{1'b0}};
      end else if (gnt_s[int'(REQ_EXU)]) begin
         rf_wen_r   <= (exu_waddr != {ADDR_WIDTH{1'b0}});
         rf_waddr_r <= exu_waddr;
         rf_wdata_r <= exu_wdata;
      end else if (gnt_s[int'(REQ_LSU)]) begin
         rf_wen_r   <= (lsu_waddr != {ADDR_WIDTH{1'b0}});
         rf_waddr_r <= lsu_waddr;
         rf_wdata_r <= lsu_wdata;
      end else begin
         rf_wen_r   <= 1'b0;
         rf_waddr_r <= rf_waddr_r;
         rf_wdata_r <= rf_wdata_r;
      end
   end

   assign issue_ready_s = !rst && ((issue_rd == {ADDR_WIDTH{1'b0}}) ||
                                   (cnt_r[issue_rd] != CNT_MAX));
   assign inc_s = issue_valid && issue_ready_s && (issue_rd != {ADDR_WIDTH{1'b0}});

   // Pending-write counters; entry 0 is tied to zero so x0 never reports busy.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NREG; i++) begin
         if (rst || (i == 0)) begin
            cnt_r[i] <= {CNT_W{1'b0}};
         end else begin
            cnt_r[i] <= cnt_step(cnt_r[i],
                                 inc_s && (issue_rd == ADDR_WIDTH'(i)),
                                 rf_wen_r && (rf_waddr_r == ADDR_WIDTH'(i)));
         end
      end
   end

   assign issue_ready = issue_ready_s;

`ifdef YSYX_23060184_RF_BYPASS_EN
   assign rs1_fwd      = rf_wen_r && (rf_waddr_r == rs1) && (rs1 != {ADDR_WIDTH{1'b0}});
   assign rs2_fwd      = rf_wen_r && (rf_waddr_r == rs2) && (rs2 != {ADDR_WIDTH{1'b0}});
   assign rs1_fwd_data = rf_wdata_r;
   assign rs2_fwd_data = rf_wdata_r;
   // The last outstanding write retiring this cycle is covered by the forward path.
   assign rs1_busy = (cnt_r[rs1] != {CNT_W{1'b0}}) &&
                     !(rs1_fwd && (cnt_r[rs1] == CNT_W'(1)));
   assign rs2_busy = (cnt_r[rs2] != {CNT_W{1'b0}}) &&
                     !(rs2_fwd && (cnt_r[rs2] == CNT_W'(1)));
`else
   assign rs1_busy = (cnt_r[rs1] != {CNT_W{1'b0}});
   assign rs2_busy = (cnt_r[rs2] != {CNT_W{1'b0}});
`endif

   assign rf_wen   = rf_wen_r;
   assign rf_waddr = rf_waddr_r;
   assign rf_wdata = rf_wdata_r;

endmodule

// File: tb/tb_ysyx_23060184_rf_wb_arb.sv
// Scoreboard bench for ysyx_23060184_rf_wb_arb: directed scenarios then random traffic.
module tb_ysyx_23060184_rf_wb_arb;

   localparam int AW = 5;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          exu_valid = 1'b0, lsu_valid = 1'b0, issue_valid = 1'b0;
   logic [AW-1:0] exu_waddr = '0, lsu_waddr = '0, issue_rd = '0, rs1 = '0, rs2 = '0;
   logic [DW-1:0] exu_wdata = '0, lsu_wdata = '0;
   logic          exu_ready, lsu_ready, issue_ready, rs1_busy, rs2_busy, rf_wen;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
`ifdef YSYX_23060184_RF_BYPASS_EN
   logic          rs1_fwd, rs2_fwd;
   logic [DW-1:0] rs1_fwd_data, rs2_fwd_data;
`endif

   ysyx_23060184_rf_wb_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst),
      .exu_valid(exu_valid), .exu_waddr(exu_waddr), .exu_wdata(exu_wdata), .exu_ready(exu_ready),
      .lsu_valid(lsu_valid), .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata), .lsu_ready(lsu_ready),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
      .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
`ifdef YSYX_23060184_RF_BYPASS_EN
      .rs1_fwd(rs1_fwd), .rs1_fwd_data(rs1_fwd_data),
      .rs2_fwd(rs2_fwd), .rs2_fwd_data(rs2_fwd_data),
`endif
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            cyc;
   } wr_t;

   wr_t           exp_q[$];
   int            n_cmp = 0;
   int            n_err = 0;
   int            cyc = 0;
   // Reference model: outstanding reservations per register, who was served
   // last (0 = EXU, 1 = LSU) and the write currently visible on the RF port.
   int            m_cnt[32];
   int            m_last = 1;
   bit            pend_v = 1'b0;
   int            pend_a = 0;
   logic [DW-1:0] pend_d = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
      end
   endtask

   // Monitor: every RF write must match the oldest expected write, in the expected cycle.
   always @(negedge clk) begin
      wr_t e;
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         n_cmp++;
         n_err++;
         $display("FAIL rf_missing @cyc %0d: no write seen, expected x%0d=0x%0h in cyc %0d",
                  cyc, exp_q[0].a, exp_q[0].d, exp_q[0].cyc);
         void'(exp_q.pop_front());
      end
      if (rf_wen === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL rf_unexpected @cyc %0d: got write x%0d=0x%0h expected none",
                     cyc, rf_waddr, rf_wdata);
         end else begin
            e = exp_q.pop_front();
            if (rf_waddr !== e.a || rf_wdata !== e.d || e.cyc != cyc) begin
               n_err++;
               $display("FAIL rf_write @cyc %0d: got x%0d=0x%0h expected x%0d=0x%0h in cyc %0d",
                        cyc, rf_waddr, rf_wdata, e.a, e.d, e.cyc);
            end
         end
      end
   end

   // One clock of stimulus: drive, check combinational outputs, advance the model.
   task automatic step(input bit r, input bit ev, input int ea, input int ed,
                       input bit lv, input int la, input int ld,
                       input bit iv, input int ird, input int r1, input int r2);
      bit ge, gl, eir, b1, b2, f1, f2;
      int inc_a, dec_a;
      @(posedge clk);
      #1;
      rst = r; exu_valid = ev; exu_waddr = AW'(ea); exu_wdata = DW'(ed);
      lsu_valid = lv; lsu_waddr = AW'(la); lsu_wdata = DW'(ld);
      issue_valid = iv; issue_rd = AW'(ird); rs1 = AW'(r1); rs2 = AW'(r2);
      #1;
      ge = 1'b0; gl = 1'b0;
      if (!r) begin
         if (ev && lv) begin
            ge = (m_last == 1);
            gl = !ge;
         end else begin
            ge = ev;
            gl = lv;
         end
      end
      eir = !r && (ird == 0 || m_cnt[ird] != 3);
      f1 = pend_v && pend_a == r1 && r1 != 0;
      f2 = pend_v && pend_a == r2 && r2 != 0;
      b1 = m_cnt[r1] != 0;
      b2 = m_cnt[r2] != 0;
`ifdef YSYX_23060184_RF_BYPASS_EN
      b1 = b1 && !(f1 && m_cnt[r1] == 1);
      b2 = b2 && !(f2 && m_cnt[r2] == 1);
      chk("rs1_fwd", DW'(rs1_fwd), DW'(f1));
      chk("rs2_fwd", DW'(rs2_fwd), DW'(f2));
      if (f1) chk("rs1_fwd_data", rs1_fwd_data, pend_d);
`endif
      chk("exu_ready", DW'(exu_ready), DW'(ge));
      chk("lsu_ready", DW'(lsu_ready), DW'(gl));
      chk("issue_ready", DW'(issue_ready), DW'(eir));
      chk("rs1_busy", DW'(rs1_busy), DW'(b1));
      chk("rs2_busy", DW'(rs2_busy), DW'(b2));
      if (r) begin
         foreach (m_cnt[i]) m_cnt[i] = 0;
         pend_v = 1'b0;
         m_last = 1;
      end else begin
         inc_a = (iv && eir && ird != 0) ? ird : -1;
         dec_a = pend_v ? pend_a : -1;
         if (inc_a != dec_a) begin
            if (inc_a >= 0) m_cnt[inc_a]++;
            if (dec_a >= 0 && m_cnt[dec_a] > 0) m_cnt[dec_a]--;
         end
         pend_v = 1'b0;
         if (ge || gl) begin
            pend_a = ge ? ea : la;
            pend_d = ge ? DW'(ed) : DW'(ld);
            pend_v = (pend_a != 0);
            m_last = ge ? 0 : 1;
            if (pend_v) exp_q.push_back('{a: AW'(pend_a), d: pend_d, cyc: cyc + 1});
         end
      end
   endtask

   task automatic idle(input int r1);
      step(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 0, r1, 0);
   endtask

   initial begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      step(1'b1, 1'b1, 3, 1, 1'b1, 4, 2, 1'b1, 5, 0, 0);
      step(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 0, 0, 0);
      idle(0);
      chk("reset_rf_wen", DW'(rf_wen), '0);
      chk("reset_rf_waddr", DW'(rf_waddr), '0);
      chk("reset_rf_wdata", rf_wdata, '0);
      // Lone EXU write, then four cycles of contention.
      step(1'b0, 1'b1, 5, 'h1234, 1'b0, 0, 0, 1'b0, 0, 0, 0);
      idle(0);
      repeat (4) step(1'b0, 1'b1, 6, 'h66, 1'b1, 7, 'h77, 1'b0, 0, 0, 0);
      idle(0);
      // Saturate x3 reservations, retire one, retry.
      repeat (4) step(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 3, 3, 0);
      step(1'b0, 1'b1, 3, 'h33, 1'b0, 0, 0, 1'b1, 3, 3, 0);
      repeat (3) step(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 3, 3, 0);
      // Busy tracking on x4 through its writeback.
      step(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 4, 4, 0);
      idle(4);
      step(1'b0, 1'b0, 0, 0, 1'b1, 4, 'h4444, 1'b0, 0, 4, 0);
      idle(4);
      idle(4);
      // x0 reservation and writeback have no effect.
      step(1'b0, 1'b1, 0, 'hdead, 1'b0, 0, 0, 1'b1, 0, 0, 0);
      idle(0);
      // Reset in the middle of x9 reservations.
      step(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 9, 9, 0);
      step(1'b1, 1'b1, 9, 'h99, 1'b0, 0, 0, 1'b1, 9, 9, 0);
      idle(9);
      chk("post_reset_rf_wen", DW'(rf_wen), '0);
      // Random traffic over a small register window to force collisions.
      for (int n = 0; n < 3000; n++) begin
         step(($urandom_range(0, 199) == 0),
              $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom,
              $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom,
              $urandom_range(0, 2) != 0, $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom_range(0, 7));
      end
      repeat (3) idle(0);
      chk("queue_drained", DW'(exp_q.size()), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
